// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: steps the shared datapath through
// fetch/decode/execute and drives mux selects, write enables and the ALUOp code.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Handshake: an access in FETCH, MEMRD or MEMWR completes in the cycle where
  // mem_ready = 1; the FSM holds its state and its strobes until then.

  state_e state_q, state_d;
  logic   pc_write;
  logic   branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore outputs; rst_n gates the FETCH strobes so nothing loads while held in reset.
  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready & rst_n;
        pc_write  = mem_ready & rst_n;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
          default:                                       illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_en = pc_write | (branch & zero);
  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle expected output vectors are queued
// from an instruction-level model and compared against the DUT cycle by cycle.
module tb_mips_multicycle_ctrl;

  localparam int VW = 19;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       pc_en, illegal;
  logic [3:0] state;

  int n_checks;
  int n_fails;

  logic [VW-1:0] exp_q[$];
  logic [5:0]    op_q[$];
  logic          mr_q[$];
  logic          z_q[$];

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
    .illegal(illegal), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] observed();
    return {state, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal};
  endfunction

  // Reference output table, written from the state descriptions.
  function automatic logic [VW-1:0] model(input logic [3:0] st, input logic [5:0] op,
                                          input logic mr, input logic z);
    logic io, mw, irw, rd, m2r, rw, sa, pe, il;
    logic [1:0] sb, ao, ps;
    {io, mw, irw, rd, m2r, rw, sa, pe, il} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      4'd0:  begin sb = 2'b01; irw = mr; pe = mr; end
      4'd1:  begin
        sb = 2'b11;
        il = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
      end
      4'd2:  begin sa = 1'b1; sb = 2'b10; end
      4'd3:  io = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin io = 1'b1; mw = 1'b1; end
      4'd6:  begin sa = 1'b1; ao = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pe = z; end
      4'd9:  begin sa = 1'b1; sb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin ps = 2'b10; pe = 1'b1; end
      default: ;
    endcase
    return {st, io, mw, irw, rd, m2r, rw, sa, sb, ao, ps, pe, il};
  endfunction

  // driver tasks
  task automatic push_cycle(input logic [3:0] st, input logic [5:0] op, input logic mr,
                            input logic z);
    op_q.push_back(op);
    mr_q.push_back(mr);
    z_q.push_back(z);
    exp_q.push_back(model(st, op, mr, z));
  endtask

  task automatic push_rnd(input logic [3:0] st, input logic [5:0] op);
    push_cycle(st, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Expected sequence from DECODE onward; mem_ready outside the wait states is random.
  task automatic gen_body(input logic [5:0] op, input int mwait, input logic z);
    push_rnd(4'd1, op);
    case (op)
      6'b000000: begin push_rnd(4'd6, op); push_rnd(4'd7, op); end
      6'b100011: begin
        push_rnd(4'd2, op);
        for (int i = 0; i < mwait; i++) push_cycle(4'd3, op, 1'b0, 1'($urandom_range(0, 1)));
        push_cycle(4'd3, op, 1'b1, 1'($urandom_range(0, 1)));
        push_rnd(4'd4, op);
      end
      6'b101011: begin
        push_rnd(4'd2, op);
        for (int i = 0; i < mwait; i++) push_cycle(4'd5, op, 1'b0, 1'($urandom_range(0, 1)));
        push_cycle(4'd5, op, 1'b1, 1'($urandom_range(0, 1)));
      end
      6'b000100: push_cycle(4'd8, op, 1'($urandom_range(0, 1)), z);
      6'b001000: begin push_rnd(4'd9, op); push_rnd(4'd10, op); end
      6'b000010: push_rnd(4'd11, op);
      default: ;
    endcase
  endtask

  task automatic gen_instr(input logic [5:0] op, input int fwait, input int mwait,
                           input logic z);
    for (int i = 0; i < fwait; i++) push_cycle(4'd0, op, 1'b0, 1'($urandom_range(0, 1)));
    push_cycle(4'd0, op, 1'b1, 1'($urandom_range(0, 1)));
    gen_body(op, mwait, z);
  endtask

  // Called just after a rising edge: drive, settle, compare, advance one cycle.
  task automatic drain(input string tag);
    logic [VW-1:0] e;
    while (exp_q.size() > 0) begin
      #1;
      opcode    = op_q.pop_front();
      mem_ready = mr_q.pop_front();
      zero      = z_q.pop_front();
      #1;
      e = exp_q.pop_front();
      check_val(tag, 32'(observed()), 32'(e));
      @(posedge clk);
    end
  endtask

  logic [5:0] ops_tbl[7];

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    opcode    = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    ops_tbl = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b010101};

    // reset values, with mem_ready high to show the FETCH strobes are held off
    #3;
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_ir_write", 32'(ir_write), 32'd0);
    check_val("rst_pc_en", 32'(pc_en), 32'd0);
    check_val("rst_selects", 32'({iord, alu_src_b, alu_op, pc_src}), 32'b0_01_00_00);
    #7;
    mem_ready = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);

    gen_instr(6'b000000, 0, 0, 1'b0);  drain("rtype");
    gen_instr(6'b100011, 0, 2, 1'b0);  drain("lw_wait2");
    gen_instr(6'b101011, 1, 2, 1'b0);  drain("sw_wait2");
    gen_instr(6'b000100, 0, 0, 1'b1);  drain("beq_taken");
    gen_instr(6'b000100, 0, 0, 1'b0);  drain("beq_not_taken");
    gen_instr(6'b111111, 3, 0, 1'b0);  drain("fetch_stall_illegal");
    gen_instr(6'b001000, 0, 0, 1'b0);  drain("addi");
    gen_instr(6'b000010, 0, 0, 1'b0);  drain("jump");

    // asynchronous reset in the middle of EXEC
    push_cycle(4'd0, 6'b000000, 1'b1, 1'b0);
    push_rnd(4'd1, 6'b000000);
    drain("pre_reset");
    #1;
    check_val("in_exec", 32'(state), 32'd6);
    #2 rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_val("async_rst_state", 32'(state), 32'd0);
    check_val("async_rst_strobes", 32'({reg_write, pc_en, mem_write, ir_write}), 32'd0);
    @(posedge clk);
    #2;
    check_val("rst_held_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_decode", 32'(state), 32'd1);
    push_rnd(4'd6, 6'b000000);
    push_rnd(4'd7, 6'b000000);
    @(posedge clk);
    drain("post_rst_rtype");

    // random instruction mix with random wait states
    for (int n = 0; n < 20; n++) begin
      gen_instr(ops_tbl[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)));
      drain("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
